sprite_line_engine: RTL and testbench

- Parametrised, line-buffered sprite renderer driven by the existing 640x480 VGA timing (hcount 0..1599, vcount 0..524; pixel x = hcount[10:1]).
- Replaces per-pixel comparison against every object. While line L is displayed, an FSM builds line L+1 into a ping-pong back buffer using a 1-cycle-latency sprite ROM. Buffers swap at end of line.
- Sits between the Avalon slave interface and the VGA output mux of the game top level.

---
 rtl/sprite_pkg.sv | 34 +++
 rtl/line_buffer_dp.sv | 28 ++
 rtl/sprite_line_engine.sv | 250 +++++++++++++++++++++++++
 tb/tb_sprite_line_engine.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite line engine.
//   obj_t          - packed object word as written over Avalon
//                    {x[31:20], y[19:8], sprite[7:2], active[1], flag[0]}
//   BG_ADDR/PAL_BASE/OBJ_BASE - Avalon word-address map
//   H_VIS_END/H_SWAP/V_VIS_END/V_LAST - VGA timing points (hcount/vcount units)
//   build_state_t  - line builder FSM states
package sprite_pkg;

  localparam int BG_ADDR   = 0;
  localparam int PAL_BASE  = 1;
  localparam int OBJ_BASE  = 16;

  localparam int H_VIS_END = 1280;
  localparam int H_SWAP    = 1599;
  localparam int V_VIS_END = 480;
  localparam int V_LAST    = 524;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [5:0]  sprite;
    logic        active;
    logic        flag;    // hflip when SPRITE_HFLIP_EN, otherwise ignored
  } obj_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SCAN,
    S_FETCH,
    S_DONE
  } build_state_t;

endpackage

// File: rtl/line_buffer_dp.sv
// line_buffer_dp: ping-pong pair of DEPTH x PIX_W simple dual-port RAMs.
//   clk       - clock
//   front_sel - bank shown to display; the other bank is the build target
//   we/wa/wd  - builder write port, always into the back bank
//   ra/rd     - display read port into the front bank, 1-cycle registered
// No reset: contents are undefined until the builder clears a bank.
module line_buffer_dp #(
  parameter int DEPTH = 640,
  parameter int PIX_W = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             front_sel,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [PIX_W-1:0] wd,
  input  logic [AW-1:0]    ra,
  output logic [PIX_W-1:0] rd
);

  logic [PIX_W-1:0] mem [2][DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[~front_sel][wa] <= wd;
    rd <= mem[front_sel][ra];
  end

endmodule

// File: rtl/sprite_line_engine.sv
// sprite_line_engine: line-buffered sprite renderer on 640x480 VGA timing.
// While line L is displayed the builder FSM renders line L+1 into the back
// half of a ping-pong line buffer; halves swap at hcount==1599.
//   clk, reset                   - 50 MHz clock, async active-high reset
//   chipselect/write/read/address/writedata/readdata
//                                - Avalon slave: 0 bg colour / status,
//                                  1..15 palette, 16.. object words
//   hcount, vcount               - VGA counters (pixel x = hcount[10:1])
//   rom_addr, rom_data           - sprite ROM {sprite,row,col}, 1-cycle latency
//   rgb                          - registered pixel colour, 2 clk after hcount
// Optional: define SPRITE_HFLIP_EN to make object bit 0 a horizontal flip.
module sprite_line_engine
  import sprite_pkg::*;
#(
  parameter int NUM_OBJ      = 32,
  parameter int MAX_PER_LINE = 8,
  parameter int SPRITE_W     = 16,
  parameter int SPRITE_H     = 16,
  parameter int PIX_W        = 4,
  parameter int HACTIVE_PIX  = 640,
  parameter int ADDR_W       = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                chipselect,
  input  logic                write,
  input  logic                read,
  input  logic [ADDR_W-1:0]   address,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic [10:0]         hcount,
  input  logic [9:0]          vcount,
  output logic [6+$clog2(SPRITE_H)+$clog2(SPRITE_W)-1:0] rom_addr,
  input  logic [PIX_W-1:0]    rom_data,
  output logic [23:0]         rgb
);

  localparam int CW   = $clog2(SPRITE_W);
  localparam int RW   = $clog2(SPRITE_H);
  localparam int OW   = $clog2(NUM_OBJ);
  localparam int DW   = $clog2(MAX_PER_LINE + 1);
  localparam int XW   = $clog2(HACTIVE_PIX);
  localparam int NPAL = (1 << PIX_W) - 1;

  // ---------------- register file ----------------
  logic [23:0] bg;
  logic [23:0] pal [1:NPAL];
  obj_t        objs [NUM_OBJ];

  logic          wr_en, rd_en, stat_rd;
  logic [OW-1:0] obj_off;

  assign wr_en   = chipselect && write;
  assign rd_en   = chipselect && read;
  assign stat_rd = rd_en && (address == ADDR_W'(BG_ADDR));
  assign obj_off = OW'(address - ADDR_W'(OBJ_BASE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bg <= 24'h000020;
      for (int i = 1; i <= NPAL; i++) pal[i] <= '0;
      for (int i = 0; i < NUM_OBJ; i++) objs[i] <= '0;
    end else if (wr_en) begin
      if (address == ADDR_W'(BG_ADDR))
        bg <= writedata[23:0];
      else if (address < ADDR_W'(PAL_BASE + NPAL))
        pal[PIX_W'(address)] <= writedata[23:0];
      else if (address >= ADDR_W'(OBJ_BASE) && address < ADDR_W'(OBJ_BASE + NUM_OBJ))
        objs[obj_off] <= obj_t'(writedata);
    end
  end

  // ---------------- builder FSM ----------------
  build_state_t    state, state_n;
  logic [9:0]      nl;          // line being built
  logic [XW-1:0]   clr_cnt;
  logic [OW-1:0]   obj_idx;
  logic [DW-1:0]   drawn;
  logic [CW:0]     fcnt;        // 0..SPRITE_W; MSB marks the drain cycle
  logic [11:0]     f_x;
  logic [RW-1:0]   f_row;
  logic [5:0]      f_spr;
  logic [CW-1:0]   rom_col;
  logic            p_vld;       // ROM data for p_x arrives this cycle
  logic [12:0]     p_x;         // 13 bits so x+col never wraps
  logic            front_sel, shown, overflow, overrun;

  obj_t        cur;
  logic [11:0] dy;
  logic        hit, last_obj, swap, line_start;
  logic        set_ovf, set_ovr, adv, take;

  assign cur        = objs[obj_idx];
  // Unsigned 12-bit difference: objects below the line wrap to a huge dy.
  assign dy         = {2'b0, nl} - cur.y;
  assign hit        = cur.active && (dy < 12'(SPRITE_H));
  assign last_obj   = (obj_idx == OW'(NUM_OBJ - 1));
  assign swap       = (hcount == 11'(H_SWAP));
  assign line_start = (hcount == 11'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    set_ovf = 1'b0;
    set_ovr = 1'b0;
    adv     = 1'b0;
    take    = 1'b0;
    case (state)
      S_IDLE:  if (line_start) state_n = S_CLEAR;
      S_CLEAR: if (clr_cnt == XW'(HACTIVE_PIX - 1))
                 state_n = (nl < 10'(V_VIS_END)) ? S_SCAN : S_DONE;
      S_SCAN: begin
        if (hit && drawn < DW'(MAX_PER_LINE)) begin
          take    = 1'b1;
          state_n = S_FETCH;
        end else begin
          set_ovf = hit;
          adv     = 1'b1;
          if (last_obj) state_n = S_DONE;
        end
      end
      S_FETCH: if (fcnt[CW]) begin
        adv     = 1'b1;
        state_n = last_obj ? S_DONE : S_SCAN;
      end
      S_DONE:  ;
      default: state_n = S_IDLE;
    endcase
    // Swap wins over everything; an unfinished build is shown as-is.
    if (swap) begin
      state_n = S_IDLE;
      set_ovr = (state != S_DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nl        <= '0;
      clr_cnt   <= '0;
      obj_idx   <= '0;
      drawn     <= '0;
      fcnt      <= '0;
      f_x       <= '0;
      f_row     <= '0;
      f_spr     <= '0;
      p_vld     <= 1'b0;
      p_x       <= '0;
      front_sel <= 1'b0;
      shown     <= 1'b0;
      overflow  <= 1'b0;
      overrun   <= 1'b0;
      readdata  <= '0;
    end else begin
      if (state == S_IDLE && line_start)
        nl <= (vcount == 10'(V_LAST)) ? 10'd0 : vcount + 10'd1;
      if (state == S_CLEAR) begin
        clr_cnt <= clr_cnt + XW'(1);
        obj_idx <= '0;
        drawn   <= '0;
      end else begin
        clr_cnt <= '0;
      end
      if (adv) obj_idx <= obj_idx + OW'(1);
      if (take) begin
        f_x   <= cur.x;
        f_row <= dy[RW-1:0];
        f_spr <= cur.sprite;
        drawn <= drawn + DW'(1);
      end
      if (take)                  fcnt <= '0;
      else if (state == S_FETCH) fcnt <= fcnt + (CW+1)'(1);
      // In-flight pixel is dropped at swap so it cannot land in the new front.
      p_vld <= (state == S_FETCH) && !fcnt[CW] && !swap;
      p_x   <= {1'b0, f_x} + 13'(fcnt);
      if (swap) begin
        front_sel <= ~front_sel;
        shown     <= 1'b1;
      end
      // A set in the same cycle as a status read is kept, not lost.
      overflow <= set_ovf || (overflow && !stat_rd);
      overrun  <= set_ovr || (overrun && !stat_rd);
      if (rd_en) readdata <= stat_rd ? {30'b0, overrun, overflow} : 32'd0;
    end
  end

`ifdef SPRITE_HFLIP_EN
  logic f_hflip;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     f_hflip <= 1'b0;
    else if (take) f_hflip <= cur.flag;
  end
  // W is a power of 2, so W-1-col is the bitwise complement.
  assign rom_col = f_hflip ? ~fcnt[CW-1:0] : fcnt[CW-1:0];
`else
  logic unused_flag;
  assign unused_flag = cur.flag;
  assign rom_col     = fcnt[CW-1:0];
`endif

  assign rom_addr = {f_spr, f_row, rom_col};

  // ---------------- line buffer ----------------
  logic             pix_ok, lb_we;
  logic [XW-1:0]    lb_wa, rd_x;
  logic [PIX_W-1:0] lb_wd, lb_rd;

  assign pix_ok = p_vld && (rom_data != '0) && (p_x < 13'(HACTIVE_PIX));
  assign lb_we  = (state == S_CLEAR) || pix_ok;
  assign lb_wa  = (state == S_CLEAR) ? clr_cnt : p_x[XW-1:0];
  assign lb_wd  = (state == S_CLEAR) ? '0 : rom_data;
  // x >= HACTIVE_PIX reads land in the blanked region and are discarded.
  assign rd_x   = XW'(hcount[10:1]);

  line_buffer_dp #(.DEPTH(HACTIVE_PIX), .PIX_W(PIX_W)) u_lbuf (
    .clk       (clk),
    .front_sel (front_sel),
    .we        (lb_we),
    .wa        (lb_wa),
    .wd        (lb_wd),
    .ra        (rd_x),
    .rd        (lb_rd)
  );

  // ---------------- display path ----------------
  logic        vis, vis_d;
  logic [23:0] color;

  // Nothing is shown before the first swap: the buffer RAM is not reset.
  assign vis = shown && (hcount < 11'(H_VIS_END)) && (vcount < 10'(V_VIS_END));

  always_comb begin
    color = bg;
    if (lb_rd != '0) color = pal[lb_rd];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vis_d <= 1'b0;
      rgb   <= '0;
    end else begin
      vis_d <= vis;
      rgb   <= vis_d ? color : 24'd0;
    end
  end

endmodule

// File: tb/tb_sprite_line_engine.sv
// tb_sprite_line_engine: directed bench for sprite_line_engine.
// Drives VGA counters line by line (vcount may jump), models the sprite ROM,
// captures each line's visible pixels and checks hand-computed colours.
// Honours SPRITE_HFLIP_EN for the flip expectations.
module tb_sprite_line_engine;

  localparam int ADDR_W = 6;
  localparam logic [23:0] BG  = 24'h000020;
  localparam logic [23:0] RED = 24'hFF0000;
  localparam logic [23:0] GRN = 24'h00FF00;
  localparam logic [23:0] BLU = 24'h0000FF;
  localparam logic [23:0] CYN = 24'h00FFFF;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [10:0]       hcount = 11'd1600;
  logic [9:0]        vcount = 10'd0;
  logic [13:0]       rom_addr;
  logic [3:0]        rom_data = '0;
  logic [23:0]       rgb;

  logic [3:0]  rom [16384];
  logic [23:0] cap [640];
  logic [23:0] hblank_px = '0;
  logic [10:0] hd1 = 11'd1600, hd2 = 11'd1600;
  int n_tests = 0, n_fail = 0;

  always #10 clk = ~clk;

  sprite_line_engine dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .hcount     (hcount),
    .vcount     (vcount),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rgb        (rgb)
  );

  // Synchronous sprite ROM, 1-cycle latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // rgb lags hcount by 2 clocks; record each even hcount's pixel.
  always @(posedge clk) begin
    hd1 <= hcount;
    hd2 <= hd1;
  end
  always @(negedge clk) begin
    if (hd2 < 11'd1280 && !hd2[0]) cap[hd2[10:1]] = rgb;
    if (hd2 == 11'd1280) hblank_px = rgb;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int count_bad(input int lo, input int hi, input logic [23:0] exp);
    int n;
    n = 0;
    for (int x = lo; x <= hi; x++) if (cap[x] !== exp) n++;
    return n;
  endfunction

  function automatic logic [31:0] mk_obj(input int x, input int y, input int spr,
                                         input logic act, input logic flip);
    return {12'(x), 12'(y), 6'(spr), act, flip};
  endfunction

  task automatic av_wr(input int a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = ADDR_W'(a); writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic av_rd(input int a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = ADDR_W'(a);
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  // One full line; hcount is parked off-range afterwards so no swap or
  // line start happens while registers are poked between lines.
  task automatic run_line(input int v);
    for (int h = 0; h < 1600; h++) begin
      hcount = 11'(h); vcount = 10'(v);
      @(posedge clk); #1;
    end
    hcount = 11'd1600;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [13:0] av;
    // sprite 2: solid 1; sprite 3: cols 0..7 = 2, rest clear; sprite 4: index = col
    for (int a = 0; a < 16384; a++) begin
      av = 14'(a);
      case (av[13:8])
        6'd2:    rom[a] = 4'd1;
        6'd3:    rom[a] = (av[3:0] < 4'd8) ? 4'd2 : 4'd0;
        6'd4:    rom[a] = av[3:0];
        default: rom[a] = 4'd0;
      endcase
    end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", rgb, 0);
    chk("rst_readdata", readdata, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    av_rd(0, rd);
    chk("rst_status", rd, 0);
    run_line(0);
    chk("preswap_blank", cap[10], 0);
    run_line(1);
    chk("bg_x0", cap[0], BG);
    chk("bg_x639", cap[639], BG);
    chk("bg_line", count_bad(0, 639, BG), 0);
    chk("hblank", hblank_px, 0);

    // single sprite
    av_wr(1, 32'h00FF0000);
    av_wr(16, mk_obj(100, 50, 2, 1'b1, 1'b0));
    run_line(49); run_line(50);
    chk("s1_x99", cap[99], BG);
    chk("s1_x100", cap[100], RED);
    chk("s1_x115", cap[115], RED);
    chk("s1_x116", cap[116], BG);
    chk("s1_span", count_bad(100, 115, RED), 0);
    run_line(64); run_line(65);
    chk("s1_line65", cap[108], RED);
    run_line(66);
    chk("s1_line66", cap[108], BG);

    // priority: obj5 over obj0, transparent half shows obj0
    av_wr(2, 32'h0000FF00);
    av_wr(21, mk_obj(100, 50, 3, 1'b1, 1'b0));
    run_line(49); run_line(50);
    chk("pri_x100", cap[100], GRN);
    chk("pri_x107", cap[107], GRN);
    chk("pri_x108", cap[108], RED);
    chk("pri_x115", cap[115], RED);

    // per-line limit and overflow flag
    for (int i = 0; i < 10; i++) av_wr(16 + i, mk_obj(40 * i, 200, 2, 1'b1, 1'b0));
    av_rd(0, rd);
    chk("ovf_pre", rd, 0);
    run_line(199); run_line(200);
    chk("lim_obj0", cap[0], RED);
    chk("lim_obj7", cap[295], RED);
    chk("lim_obj8", cap[320], BG);
    chk("lim_obj9", cap[370], BG);
    av_rd(0, rd);
    chk("ovf_set", rd, 1);
    av_rd(0, rd);
    chk("ovf_clr", rd, 0);

    // right edge clip and bottom edge
    for (int i = 0; i < 10; i++) av_wr(16 + i, 32'd0);
    av_wr(17, mk_obj(630, 300, 2, 1'b1, 1'b0));
    av_wr(18, mk_obj(50, 470, 2, 1'b1, 1'b0));
    run_line(299); run_line(300);
    chk("edge_x629", cap[629], BG);
    chk("edge_x630", cap[630], RED);
    chk("edge_x639", cap[639], RED);
    chk("edge_nowrap", count_bad(0, 5, BG), 0);
    run_line(469); run_line(470);
    chk("bot_line470", cap[50], RED);
    run_line(478); run_line(479);
    chk("bot_line479", cap[55], RED);
    run_line(480);
    chk("vblank_480", cap[55], 0);
    run_line(524); run_line(0);
    chk("bot_line0", cap[50], BG);

    // hflip (gradient sprite, index = rom col)
    av_wr(15, 32'h000000FF);
    av_wr(14, 32'h0000FFFF);
    av_wr(19, mk_obj(200, 100, 4, 1'b1, 1'b1));
    run_line(99); run_line(100);
`ifdef SPRITE_HFLIP_EN
    chk("flip_x200", cap[200], BLU);
    chk("flip_x201", cap[201], CYN);
    chk("flip_x215", cap[215], BG);
`else
    chk("flip_x200", cap[200], BG);
    chk("flip_x201", cap[201], RED);
    chk("flip_x215", cap[215], BLU);
`endif

    // reset mid-line
    for (int h = 0; h < 700; h++) begin
      hcount = 11'(h); vcount = 10'd5;
      @(posedge clk); #1;
    end
    chk("mid_pre", rgb, BG);
    reset = 1'b1;
    #1;
    chk("mid_rgb", rgb, 0);
    hcount = 11'd1600;
    @(posedge clk); #1;
    reset = 1'b0;
    av_rd(0, rd);
    chk("mid_status", rd, 0);
    run_line(99);
    chk("mid_blank", cap[200], 0);
    run_line(100);
    chk("mid_objs_off", cap[200], BG);
    chk("mid_line", count_bad(0, 639, BG), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
